// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver and make/break decoder.
// Drives held-key levels for the game logic plus raw byte/error strobes.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 40000,
  parameter int TO_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] keyboard_out,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      c_sync_q;
  logic [1:0]      d_sync_q;
  logic            c_prev_q;
  logic            fall;
  logic            din;

  state_t          state_q;
  logic [2:0]      cnt_q;
  logic [7:0]      sh_q;
  logic            par_q;
  logic [TO_W-1:0] to_q;
  logic            ext_q;
  logic            brk_q;
  logic [3:0]      kb_q;
  logic [7:0]      code_q;
  logic            cv_q;
  logic            fe_q;

  assign fall = c_prev_q & ~c_sync_q[1];
  assign din  = d_sync_q[1];

  assign keyboard_out = kb_q;
  assign scan_code    = code_q;
  assign code_valid   = cv_q;
  assign frame_err    = fe_q;

  // Two-flop synchronisers; idle-high reset so no false edge on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      c_prev_q <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2_clk};
      d_sync_q <= {d_sync_q[0], ps2_data};
      c_prev_q <= c_sync_q[1];
    end
  end

  // Frame receiver, timeout, prefix tracking and key-level decoding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sh_q    <= 8'h00;
      par_q   <= 1'b0;
      to_q    <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      kb_q    <= 4'b0000;
      code_q  <= 8'h00;
      cv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      cv_q <= 1'b0;
      fe_q <= 1'b0;

      // Act on the byte strobed last cycle.
      if (cv_q) begin
        unique case (1'b1)
          code_q == 8'hE0: ext_q <= 1'b1;
          code_q == 8'hF0: brk_q <= 1'b1;
          default: begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            unique case (1'b1)
              code_q == 8'h5A:
                kb_q[0] <= ~brk_q;
              code_q == 8'h75 && ext_q:
                kb_q[1] <= ~brk_q;
              code_q == 8'h72 && ext_q:
                kb_q[2] <= ~brk_q;
              code_q == 8'h76 && !ext_q:
                kb_q[3] <= ~brk_q;
              default: ;
            endcase
          end
        endcase
      end

      if (fall) begin
        to_q <= '0;
        unique case (state_q)
          IDLE: begin
            if (!din) begin
              state_q <= DATA;
              cnt_q   <= 3'd0;
              par_q   <= 1'b0;
            end else begin
              fe_q <= 1'b1;
            end
          end
          DATA: begin
            sh_q  <= {din, sh_q[7:1]};
            par_q <= par_q ^ din;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= par_q ^ din;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (din && par_q) begin
              cv_q   <= 1'b1;
              code_q <= sh_q;
            end else begin
              fe_q  <= 1'b1;
              ext_q <= 1'b0;
              brk_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (to_q == TO_LAST) begin
          state_q <= IDLE;
          fe_q    <= 1'b1;
          ext_q   <= 1'b0;
          brk_q   <= 1'b0;
        end else begin
          to_q <= to_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder.
// Bit-bangs PS/2 frames and checks strobes and key levels.
module tb_ps2_key_decoder;

  localparam int TO = 400;
  localparam int HP = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] keyboard_out;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  int checks = 0;
  int failures = 0;

  int         cv_cnt = 0;
  int         fe_cnt = 0;
  int         both_cnt = 0;
  int         bad_kb_cnt = 0;
  logic [7:0] last_code = 8'h00;
  logic [3:0] kb_at_cv = 4'h0;
  logic [3:0] kb_after_cv = 4'h0;
  logic       prev_cv = 1'b0;
  logic [3:0] prev_kb = 4'h0;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(TO),
    .TO_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .keyboard_out(keyboard_out),
    .scan_code(scan_code),
    .code_valid(code_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      prev_cv = 1'b0;
      prev_kb = keyboard_out;
    end else begin
      if (prev_cv) kb_after_cv = keyboard_out;
      if (keyboard_out != prev_kb && !prev_cv)
        bad_kb_cnt++;
      if (code_valid) begin
        cv_cnt++;
        last_code = scan_code;
        kb_at_cv = keyboard_out;
      end
      if (frame_err) fe_cnt++;
      if (code_valid && frame_err) both_cnt++;
      prev_cv = code_valid;
      prev_kb = keyboard_out;
    end
  end

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HP) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HP) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HP) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~^b ^ bad_par;
    send_bits({1'b1, p, b, 1'b0}, 11);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (keyboard_out !== 4'h0 || scan_code !== 8'h00 ||
        code_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals kb=%h sc=%h cv=%b fe=%b want 0",
               keyboard_out, scan_code, code_valid, frame_err);
    end
    rst = 1'b1;
    repeat (2000) @(posedge clk);
    checks++;
    if (cv_cnt != 0 || fe_cnt != 0 || keyboard_out !== 4'h0) begin
      failures++;
      $display("FAIL idle_quiet cv=%0d fe=%0d kb=%h want 0 0 0",
               cv_cnt, fe_cnt, keyboard_out);
    end
  endtask

  task automatic test_enter;
    send(8'h5A, 1'b0);
    checks++;
    if (cv_cnt != 1 || last_code !== 8'h5A) begin
      failures++;
      $display("FAIL enter_code cnt=%0d code=%h want 1 5a",
               cv_cnt, last_code);
    end
    checks++;
    if (kb_at_cv !== 4'h0 || kb_after_cv !== 4'h1) begin
      failures++;
      $display("FAIL enter_lat at=%h after=%h want 0 1",
               kb_at_cv, kb_after_cv);
    end
    send(8'hF0, 1'b0);
    send(8'h5A, 1'b0);
    checks++;
    if (keyboard_out !== 4'h0 || scan_code !== 8'h5A) begin
      failures++;
      $display("FAIL enter_brk kb=%h sc=%h want 0 5a",
               keyboard_out, scan_code);
    end
  endtask

  task automatic test_arrows;
    send(8'hE0, 1'b0);
    send(8'h75, 1'b0);
    send(8'hE0, 1'b0);
    send(8'h72, 1'b0);
    checks++;
    if (keyboard_out !== 4'b0110) begin
      failures++;
      $display("FAIL arrows_make kb=%b want 0110", keyboard_out);
    end
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h75, 1'b0);
    checks++;
    if (keyboard_out !== 4'b0100) begin
      failures++;
      $display("FAIL up_brk kb=%b want 0100", keyboard_out);
    end
    send(8'h75, 1'b0);
    checks++;
    if (keyboard_out !== 4'b0100 || scan_code !== 8'h75) begin
      failures++;
      $display("FAIL kp8 kb=%b sc=%h want 0100 75",
               keyboard_out, scan_code);
    end
  endtask

  task automatic test_parity;
    int cv0;
    int fe0;
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    send(8'h76, 1'b1);
    checks++;
    if (fe_cnt - fe0 != 1 || cv_cnt != cv0) begin
      failures++;
      $display("FAIL par_err fe=%0d cv=%0d want 1 0",
               fe_cnt - fe0, cv_cnt - cv0);
    end
    checks++;
    if (keyboard_out !== 4'b0100 || scan_code !== 8'h75) begin
      failures++;
      $display("FAIL par_hold kb=%b sc=%h want 0100 75",
               keyboard_out, scan_code);
    end
    send(8'h76, 1'b0);
    checks++;
    if (keyboard_out !== 4'b1100 || scan_code !== 8'h76) begin
      failures++;
      $display("FAIL esc kb=%b sc=%h want 1100 76",
               keyboard_out, scan_code);
    end
  endtask

  task automatic test_timeout;
    int cv0;
    int fe0;
    logic [10:0] f;
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    f = {1'b1, 1'b1, 8'h5A, 1'b0};
    send_bits(f, 5);
    repeat (TO + 50) @(posedge clk);
    checks++;
    if (fe_cnt - fe0 != 1 || cv_cnt != cv0) begin
      failures++;
      $display("FAIL timeout fe=%0d cv=%0d want 1 0",
               fe_cnt - fe0, cv_cnt - cv0);
    end
    send(8'h5A, 1'b0);
    checks++;
    if (keyboard_out !== 4'b1101 || scan_code !== 8'h5A ||
        fe_cnt - fe0 != 1) begin
      failures++;
      $display("FAIL after_to kb=%b sc=%h fe=%0d want 1101 5a 1",
               keyboard_out, scan_code, fe_cnt - fe0);
    end
  endtask

  task automatic test_mid_reset;
    logic [10:0] f;
    send(8'hE0, 1'b0);
    send(8'h75, 1'b0);
    checks++;
    if (keyboard_out !== 4'b1111) begin
      failures++;
      $display("FAIL all_held kb=%b want 1111", keyboard_out);
    end
    f = {1'b1, 1'b0, 8'h76, 1'b0};
    send_bits(f, 4);
    rst = 1'b0;
    #1;
    checks++;
    if (keyboard_out !== 4'h0 || scan_code !== 8'h00 ||
        code_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst kb=%h sc=%h cv=%b fe=%b want 0",
               keyboard_out, scan_code, code_valid, frame_err);
    end
    repeat (5) @(posedge clk);
    rst = 1'b1;
    cv_cnt = 0;
    fe_cnt = 0;
    send(8'h76, 1'b0);
    checks++;
    if (keyboard_out !== 4'b1000 || scan_code !== 8'h76 ||
        cv_cnt != 1 || fe_cnt != 0) begin
      failures++;
      $display("FAIL post_rst kb=%b sc=%h cv=%0d fe=%0d want 1000 76 1 0",
               keyboard_out, scan_code, cv_cnt, fe_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_enter;
    test_arrows;
    test_parity;
    test_timeout;
    test_mid_reset;
    checks++;
    if (both_cnt != 0 || bad_kb_cnt != 0) begin
      failures++;
      $display("FAIL strobes both=%0d kb_glitch=%0d want 0 0",
               both_cnt, bad_kb_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
